// File: rtl/exec_pkg.sv
// Shared types for the execute stage: mul/div FSM states, M-extension ops,
// forwarding selects and ALU control encodings.
package exec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    FWD_RD = 2'd0,
    FWD_W  = 2'd1,
    FWD_M  = 2'd2
  } fwd_sel_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

endpackage

// File: rtl/alu.sv
// Integer ALU; zero_o carries the branch condition selected by funct3.
module alu
  import exec_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [3:0]       ctrl_i,
  input  logic [2:0]       funct3_i,
  output logic [Width-1:0] result_o,
  output logic             zero_o
);

  localparam int unsigned ShW = $clog2(Width);

  logic [ShW-1:0] shamt;
  logic           lt_s, lt_u, eq;

  assign shamt = b_i[ShW-1:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;
  assign eq    = a_i == b_i;

  always_comb begin
    result_o = '0;
    case (ctrl_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLT:  result_o = {{(Width-1){1'b0}}, lt_s};
      ALU_SLTU: result_o = {{(Width-1){1'b0}}, lt_u};
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt;
      default:  result_o = a_i + b_i;
    endcase
  end

  always_comb begin
    zero_o = eq;
    case (funct3_i)
      3'b000:  zero_o = eq;
      3'b001:  zero_o = !eq;
      3'b100:  zero_o = lt_s;
      3'b101:  zero_o = !lt_s;
      3'b110:  zero_o = lt_u;
      3'b111:  zero_o = !lt_u;
      default: zero_o = eq;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle RV32M unit: fixed-latency multiply and restoring radix-2 divide
// on magnitudes, with sign and corner-case fix-up applied in DONE.
module md_unit
  import exec_pkg::*;
#(
  parameter int unsigned DWidth    = 32,
  parameter int unsigned MulCycles = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [2:0]        op_i,
  input  logic [DWidth-1:0] a_i,
  input  logic [DWidth-1:0] b_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [DWidth-1:0] result_o
);

  localparam int unsigned MaxN = (DWidth > MulCycles) ? DWidth : MulCycles;
  localparam int unsigned CntW = (MaxN > 1) ? $clog2(MaxN) : 1;

  md_state_t         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  md_op_t            op_q, op_d;
  logic [DWidth-1:0] a_q, a_d, b_q, b_d;
  logic [DWidth-1:0] quo_q, quo_d, rem_q, rem_d;

  logic              sgn_in, sgn_q;
  logic [DWidth-1:0] a_mag_in, b_mag;
  logic [DWidth:0]   shifted, diff;

  assign sgn_in   = !op_i[0];
  assign a_mag_in = (sgn_in && a_i[DWidth-1]) ? -a_i : a_i;
  assign sgn_q    = !op_q[0];
  assign b_mag    = (sgn_q && b_q[DWidth-1]) ? -b_q : b_q;
  assign shifted  = {rem_q, quo_q[DWidth-1]};
  assign diff     = shifted - {1'b0, b_mag};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = BUSY;
          cnt_d   = op_i[2] ? CntW'(DWidth - 1) : CntW'(MulCycles - 1);
          op_d    = md_op_t'(op_i);
          a_d     = a_i;
          b_d     = b_i;
          quo_d   = a_mag_in;
          rem_d   = '0;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        // One quotient bit per BUSY cycle; divide runs exactly DWidth steps.
        if (op_q[2]) begin
          if (!diff[DWidth]) begin
            rem_d = diff[DWidth-1:0];
            quo_d = {quo_q[DWidth-2:0], 1'b1};
          end else begin
            rem_d = shifted[DWidth-1:0];
            quo_d = {quo_q[DWidth-2:0], 1'b0};
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MUL;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  logic                a_sx, b_sx;
  logic [2*DWidth-1:0] a_wide, b_wide, prod;
  logic                div0, ovf;
  logic [DWidth-1:0]   quo_fix, rem_fix, md_res;

  assign a_sx   = (op_q != MULHU) && a_q[DWidth-1];
  assign b_sx   = ((op_q == MUL) || (op_q == MULH)) && b_q[DWidth-1];
  assign a_wide = {{DWidth{a_sx}}, a_q};
  assign b_wide = {{DWidth{b_sx}}, b_q};
  assign prod   = a_wide * b_wide;

  assign div0 = b_q == '0;
  assign ovf  = sgn_q && (a_q == {1'b1, {(DWidth-1){1'b0}}}) && (b_q == '1);

  always_comb begin
    quo_fix = (sgn_q && (a_q[DWidth-1] ^ b_q[DWidth-1])) ? -quo_q : quo_q;
    rem_fix = (sgn_q && a_q[DWidth-1]) ? -rem_q : rem_q;
    if (div0) begin
      quo_fix = '1;
      rem_fix = a_q;
    end else if (ovf) begin
      quo_fix = a_q;
      rem_fix = '0;
    end
    if (op_q[2]) begin
      md_res = op_q[1] ? rem_fix : quo_fix;
    end else begin
      md_res = (op_q == MUL) ? prod[DWidth-1:0] : prod[2*DWidth-1:DWidth];
    end
  end

  always_comb begin
    stall_o = 1'b0;
    if (rst_ni && !flush_i) begin
      case (state_q)
        IDLE:    stall_o = start_i;
        BUSY:    stall_o = 1'b1;
        default: stall_o = 1'b0;
      endcase
    end
  end

  assign done_o   = rst_ni && !flush_i && (state_q == DONE);
  assign result_o = done_o ? md_res : '0;

endmodule

// File: rtl/pc_branch.sv
// Branch/jump target adder.
module pc_branch #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] pc_i,
  input  logic [Width-1:0] imm_i,
  output logic [Width-1:0] target_o
);

  assign target_o = pc_i + imm_i;

endmodule

// File: rtl/execute_md.sv
// Execute stage with operand forwarding, ALU, branch target and a stalling
// RV32M mul/div unit whose result overrides the ALU on its DONE cycle.
module execute_md
  import exec_pkg::*;
#(
  parameter int unsigned D_WIDTH    = 32,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               reg_write_e_i,
  input  logic               mem_write_e_i,
  input  logic [1:0]         result_src_e_i,
  input  logic [3:0]         alu_ctrl_e,
  input  logic               alu_src_e,
  input  logic [2:0]         ins_3,
  input  logic               md_en_e,
  input  logic               flush_e,
  input  logic [1:0]         fwd_a_e,
  input  logic [1:0]         fwd_b_e,
  input  logic [D_WIDTH-1:0] rd1_e,
  input  logic [D_WIDTH-1:0] rd2_e,
  input  logic [D_WIDTH-1:0] pc_e,
  input  logic [D_WIDTH-1:0] imm_ext_e,
  input  logic [D_WIDTH-1:0] pc_plus_4e_i,
  input  logic [D_WIDTH-1:0] result_w,
  input  logic [D_WIDTH-1:0] alu_result_m,
  input  logic [4:0]         rd_e_i,
  output logic               stall_e_o,
  output logic               zero_e,
  output logic               reg_write_e_o,
  output logic               mem_write_e_o,
  output logic [1:0]         result_src_e_o,
  output logic [D_WIDTH-1:0] alu_result,
  output logic [D_WIDTH-1:0] write_data_e,
  output logic [D_WIDTH-1:0] pc_plus_4e_o,
  output logic [D_WIDTH-1:0] pc_target_e,
  output logic [4:0]         rd_e_o
);

  logic [D_WIDTH-1:0] src_a, src_b, alu_out, md_result;
  logic               alu_zero, md_done;

  always_comb begin
    case (fwd_sel_t'(fwd_a_e))
      FWD_W:   src_a = result_w;
      FWD_M:   src_a = alu_result_m;
      default: src_a = rd1_e;
    endcase
    case (fwd_sel_t'(fwd_b_e))
      FWD_W:   write_data_e = result_w;
      FWD_M:   write_data_e = alu_result_m;
      default: write_data_e = rd2_e;
    endcase
  end

  assign src_b = alu_src_e ? imm_ext_e : write_data_e;

  alu #(
    .Width (D_WIDTH)
  ) u_alu (
    .a_i      (src_a),
    .b_i      (src_b),
    .ctrl_i   (alu_ctrl_e),
    .funct3_i (ins_3),
    .result_o (alu_out),
    .zero_o   (alu_zero)
  );

  pc_branch #(
    .Width (D_WIDTH)
  ) u_pc_branch (
    .pc_i     (pc_e),
    .imm_i    (imm_ext_e),
    .target_o (pc_target_e)
  );

  md_unit #(
    .DWidth    (D_WIDTH),
    .MulCycles (MUL_CYCLES)
  ) u_md_unit (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (md_en_e),
    .flush_i  (flush_e),
    .op_i     (ins_3),
    .a_i      (src_a),
    .b_i      (write_data_e),
    .stall_o  (stall_e_o),
    .done_o   (md_done),
    .result_o (md_result)
  );

  assign alu_result     = md_done ? md_result : alu_out;
  assign zero_e         = md_en_e ? 1'b0 : alu_zero;
  assign reg_write_e_o  = reg_write_e_i;
  assign mem_write_e_o  = mem_write_e_i;
  assign result_src_e_o = result_src_e_i;
  assign pc_plus_4e_o   = pc_plus_4e_i;
  assign rd_e_o         = rd_e_i;

endmodule

// File: doc/execute_md.md
EXECUTE_MD -- requirements
Module: execute_md

Interface
REQ-001 Parameter D_WIDTH, default 32: datapath width; SHALL be even and >=8.
REQ-002 Parameter MUL_CYCLES, default 2: multiply busy cycles; SHALL be >=1.
REQ-003 Ports SHALL be one per line: name, direction, width, meaning, with clock and reset first.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- reg_write_e_i, mem_write_e_i  in  1 each  control passthrough.
- result_src_e_i  in  2  control passthrough.
- alu_ctrl_e  in  4  ALU op.
- alu_src_e  in  1  0=forwarded rs2, 1=imm_ext_e.
- ins_3  in  3  funct3; branch compare type, or M-op when md_en_e=1.
- md_en_e  in  1  instruction is RV32M mul/div.
- flush_e  in  1  kill instruction in E.
- fwd_a_e, fwd_b_e  in  2 each  00=rdN_e, 01=result_w, 10=alu_result_m.
- rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus_4e_i, result_w, alu_result_m  in  D_WIDTH each.
- rd_e_i  in  5  destination register.
- stall_e_o  out  1  hold F/D/E; E/M register must take a bubble.
- zero_e  out  1  branch condition from ALU.
- reg_write_e_o, mem_write_e_o  out  1 each;  result_src_e_o  out  2.
- alu_result, write_data_e, pc_plus_4e_o, pc_target_e  out  D_WIDTH each.
- rd_e_o  out  5.

Function
REQ-004 src_a = forward mux(fwd_a_e); write_data_e = forward mux(fwd_b_e); src_b = alu_src_e ? imm_ext_e : write_data_e; code 11 SHALL select rdN_e.
REQ-005 pc_target_e SHALL be pc_e + imm_ext_e, mod 2^D_WIDTH; rd, pc_plus_4, and control SHALL pass through combinationally.
REQ-006 With md_en_e=0, alu_result SHALL be the combinational ALU output, and stall_e_o SHALL be 0.
REQ-007 The mul/div FSM SHALL have the states IDLE, BUSY, and DONE.
REQ-008 IDLE with md_en_e=1 and flush_e=0: stall_e_o=1 combinationally; capture src_a, write_data_e, and ins_3; load counter N-1; go to BUSY.
- N = MUL_CYCLES for funct3 0xx.
- N = D_WIDTH for funct3 1xx.
REQ-009 BUSY: stall_e_o=1; counter decrements; the state SHALL go to DONE on the cycle the counter equals 0.
REQ-010 DONE: stall_e_o=0; alu_result = md result; go to IDLE. Each md instruction SHALL hold E for exactly N+2 cycles, and the back-to-back next md op SHALL start in the following IDLE.
REQ-011 Ops: MUL low word; MULH s*s high; MULHSU s*u high; MULHU u*u high; DIV/DIVU truncating quotient; REM/REMU remainder with the dividend's sign; the product SHALL be computed at 2*D_WIDTH bits.
REQ-012 Divide SHALL be restoring, radix-2, on magnitudes, with sign fix-up in DONE.
REQ-013 Divide by zero: quotient = all ones; remainder = dividend.
REQ-014 Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
REQ-015 The REQ-013/REQ-014 latency SHALL be unchanged (fixed N).
REQ-016 flush_e=1 in any state SHALL return the FSM to IDLE next cycle with stall_e_o=0 that cycle; no result SHALL be produced; flush SHALL take priority over start.
REQ-017 Inputs SHALL only be sampled at IDLE start; changes during BUSY SHALL NOT affect the result.
REQ-018 zero_e in md mode SHALL be 0.

Reset
REQ-019 rst_n=0 at a clk edge SHALL force IDLE, counter 0, and operand and result registers 0, including mid-operation (no result emitted).
REQ-020 During reset, stall_e_o SHALL be 0; combinational outputs SHALL follow their inputs.

Structure
REQ-021 Package exec_pkg SHALL hold:
- the md_state_t enum (IDLE, BUSY, DONE);
- the md_op_t enum (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU = funct3 0-7);
- the fwd_sel_t enum (FWD_RD, FWD_W, FWD_M).
REQ-022 Sub-module md_unit SHALL contain the FSM, counter, and mul/div datapath, with a start/flush/done/result interface; the existing alu and pc_branch SHALL be reused.

Verification (D_WIDTH=32, MUL_CYCLES=2)
REQ-023 MUL 7*-3: stall high 3 cycles, DONE cycle alu_result=0xFFFFFFEB, 4 cycles total.
REQ-024 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000*0x80000000 -> 0x40000000.
REQ-025 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; both take 34 cycles with stall high 33 cycles.
REQ-026 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
REQ-027 Flush or rst_n=0 at BUSY count 10 of a DIV: stall falls within 1 cycle, IDLE state, no DONE; an immediately following ADD with fwd_a_e=10 (alu_result_m=0x10) + imm 4 gives 0x14 with no stall.
REQ-028 Back-to-back MUL, MUL: second start on the cycle after the first DONE; beq with equal forwarded operands gives zero_e=1 and pc_target_e = pc_e + imm.
